// File: rtl/fb_scanout.sv
// fb_scanout - display-side reader for the double-buffered 32x32 RGB444
// frame buffer. Generates VGA timing, walks the buffer read address across
// the cell grid (each cell scaled to CELL_W x CELL_H screen pixels), drives
// RGB and sync to the pins, and requests a buffer swap at the start of
// vertical blanking once the renderer has reported a complete frame.
//
// Ports:
//   clk          system clock (single domain)
//   rst          synchronous, active-high reset
//   frame_ready  one-clk pulse: renderer's back buffer holds a full frame
//   buf_en       buffer enable; a read or a swap happens on this edge
//   buf_swap     one-clk swap request, always together with buf_en
//   buf_addr     read address {cell_y, cell_x}
//   buf_dout     buffer read data, valid 1 clk after the enabled edge
//   red/green/blue  4-bit colour, 0 outside active video
//   hsync/vsync  active-low syncs, aligned with RGB
//   frame_done   one-clk pulse at the start of each vertical blank
module fb_scanout #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_W   = 20,
  parameter int CELL_H   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_ready,
  output logic        buf_en,
  output logic        buf_swap,
  output logic [9:0]  buf_addr,
  input  logic [11:0] buf_dout,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW  = $clog2(CLK_DIV);
  // +1 so that H_TOTAL / V_TOTAL themselves are representable in compares
  localparam int HW  = $clog2(H_TOTAL + 1);
  localparam int VW  = $clog2(V_TOTAL + 1);
  localparam int SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_ACT     = VW'(V_ACTIVE);
  localparam logic [HW-1:0]  HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SXW-1:0] SX_LAST   = SXW'(CELL_W - 1);
  localparam logic [SYW-1:0] SY_LAST   = SYW'(CELL_H - 1);

  logic [DW-1:0]  div;
  logic [HW-1:0]  h;
  logic [VW-1:0]  v;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic [4:0]     cell_x;
  logic [4:0]     cell_y;
  logic           pending;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic active;
  logic vblank;
  logic swap;
  logic hs_now;
  logic vs_now;
  logic active_d1;
  logic hs_d1;
  logic vs_d1;

  assign tick   = (div == DIV_LAST);
  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);
  assign active = (h < H_ACT) && (v < V_ACT);
  assign vblank = tick && (h == '0) && (v == V_ACT);
  assign swap   = vblank && (pending || frame_ready);

  assign buf_en     = (tick && active) || swap;
  assign buf_swap   = swap;
  assign frame_done = vblank;
  // At the vblank tick cell_y/cell_x have already wrapped to 0, but the
  // swap address is forced anyway so it never depends on the cell grid.
  assign buf_addr   = swap ? 10'd0 : {cell_y, cell_x};

  assign hs_now = !((h >= HS_START) && (h < HS_END));
  assign vs_now = !((v >= VS_START) && (v < VS_END));

  // Raster and cell counters. The cell counters track h/v exactly so the
  // address is a plain concatenation, with no divide by CELL_W/CELL_H.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      h      <= '0;
      v      <= '0;
      sx     <= '0;
      sy     <= '0;
      cell_x <= '0;
      cell_y <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h_wrap) begin
          h      <= '0;
          sx     <= '0;
          cell_x <= '0;
          if (v_wrap) begin
            v      <= '0;
            sy     <= '0;
            cell_y <= '0;
          end else begin
            v <= v + 1'b1;
            if (v < V_ACT) begin
              if (sy == SY_LAST) begin
                sy     <= '0;
                cell_y <= cell_y + 5'd1;
              end else begin
                sy <= sy + 1'b1;
              end
            end
          end
        end else begin
          h <= h + 1'b1;
          if (h < H_ACT) begin
            if (sx == SX_LAST) begin
              sx     <= '0;
              cell_x <= cell_x + 5'd1;
            end else begin
              sx <= sx + 1'b1;
            end
          end
        end
      end
    end
  end

  // A frame_ready arriving in the swap clock is consumed by that swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (swap) begin
      pending <= 1'b0;
    end else if (frame_ready) begin
      pending <= 1'b1;
    end
  end

  // Two-stage output pipeline: the buffer read takes one clk, the colour
  // register the second; syncs ride a matching two-stage delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_d1 <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      active_d1 <= active;
      hs_d1     <= hs_now;
      vs_d1     <= vs_now;
      hsync     <= hs_d1;
      vsync     <= vs_d1;
      if (active_d1) begin
        red   <= buf_dout[11:8];
        green <= buf_dout[7:4];
        blue  <= buf_dout[3:0];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout using a reduced raster (CLK_DIV=2, 64x64 active,
// 2x2 cells) so several frames fit in a short run. The reference model
// derives every expected output from the clock count since reset with
// plain arithmetic (pixel = n / CLK_DIV, h = pixel % H_TOTAL, ...).
module tb_fb_scanout;

  localparam int D   = 2;
  localparam int CW  = 2;
  localparam int CH  = 2;
  localparam int HA  = 32 * CW;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int VA  = 32 * CH;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_ready = 1'b0;
  logic        buf_en;
  logic        buf_swap;
  logic [9:0]  buf_addr;
  logic [11:0] buf_dout;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        frame_done;

  logic [11:0] mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  fb_scanout #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CELL_W(CW), .CELL_H(CH)
  ) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready),
    .buf_en(buf_en), .buf_swap(buf_swap), .buf_addr(buf_addr),
    .buf_dout(buf_dout), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame-buffer read port: registered read on enable, cleared in reset.
  always @(posedge clk) begin
    if (rst) buf_dout <= 12'd0;
    else if (buf_en) buf_dout <= mem[buf_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int n;
  longint abs_n;
  bit pend;
  bit hs1, hs2, vs1, vs2, act1, act2;
  logic [11:0] dcur, dprev;

  task automatic model_reset();
    n = 0; pend = 0;
    hs1 = 1; hs2 = 1; vs1 = 1; vs2 = 1; act1 = 0; act2 = 0;
    dcur = 12'd0; dprev = 12'd0;
  endtask

  initial begin
    int dv, p, h, v, frame;
    bit tick, act, vb, swp, en, hs_now, vs_now;
    bit post, rst_now, just_reset, prev_hs, prev_vs, done;
    logic [9:0] addr;
    int fr_h0, fr_h1, fr_h2, rst_h;
    int hrun, vrun;
    longint last_hf, last_fd;

    foreach (mem[i]) mem[i] = 12'($urandom);
    fr_h0 = $urandom_range(0, HT - 1);
    fr_h1 = $urandom_range(0, HT - 1);
    fr_h2 = $urandom_range(0, HT - 1);
    rst_h = $urandom_range(0, HT - 1);

    post = 0; rst_now = 0; just_reset = 0; done = 0;
    hrun = 0; vrun = 0; last_hf = -1; last_fd = -1;
    prev_hs = 1; prev_vs = 1; abs_n = 0;

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    model_reset();

    while (!done) begin
      dv    = n % D;
      p     = n / D;
      h     = p % HT;
      v     = (p / HT) % VT;
      frame = p / (HT * VT);
      tick  = (dv == D - 1);
      act   = (h < HA) && (v < VA);
      vb    = tick && (h == 0) && (v == VA);

      frame_ready = 1'b0;
      if (!post) begin
        if (frame == 0 && dv == 0 && v == 10 && h == fr_h0) frame_ready = 1'b1;
        if (frame == 0 && dv == 0 && v == 20 && h == fr_h1) frame_ready = 1'b1;
        if (frame == 2 && vb) frame_ready = 1'b1;
        if (frame == 4 && dv == 0 && v == 10 && h == fr_h2) frame_ready = 1'b1;
        if (frame == 4 && dv == 0 && v == 30 && h == rst_h) begin
          rst = 1'b1;
          rst_now = 1;
        end
      end

      swp  = vb && (pend || frame_ready);
      en   = (tick && act) || swp;
      addr = swp ? 10'd0 : 10'((v / CH) * 32 + (h / CW));
      #1;

      check("buf_en", 32'(buf_en), 32'(en));
      check("buf_swap", 32'(buf_swap), 32'(swp));
      check("frame_done", 32'(frame_done), 32'(vb));
      if (en) check("buf_addr", 32'(buf_addr), 32'(addr));
      check("hsync", 32'(hsync), 32'(hs2));
      check("vsync", 32'(vsync), 32'(vs2));
      check("rgb", 32'({red, green, blue}), act2 ? 32'(dprev) : 32'd0);

      if (tick && v == 0 && h == CW - 1)   check("addr_cw-1_0", 32'(buf_addr), 32'd0);
      if (tick && v == 0 && h == CW)       check("addr_cw_0", 32'(buf_addr), 32'd1);
      if (tick && v == 0 && h == HA - 1)   check("addr_last_col", 32'(buf_addr), 32'd31);
      if (tick && v == CH && h == 0)       check("addr_0_ch", 32'(buf_addr), 32'd32);
      if (tick && v == VA - 1 && h == HA - 1) check("addr_last", 32'(buf_addr), 32'd1023);
      if (vb) check("swap_at_vblank", 32'(buf_swap),
                    32'(!post && (frame == 0 || frame == 2)));

      if (just_reset) begin
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_buf_en", 32'(buf_en), 32'd0);
        just_reset = 0;
      end

      if (!hsync) hrun++;
      else begin
        if (hrun > 0) check("hsync_width", 32'(hrun), 32'(HS * D));
        hrun = 0;
      end
      if (!vsync) vrun++;
      else begin
        if (vrun > 0) check("vsync_width", 32'(vrun), 32'(VS * HT * D));
        vrun = 0;
      end
      if (prev_hs && !hsync) begin
        if (last_hf >= 0) check("line_period", 32'(abs_n - last_hf), 32'(HT * D));
        last_hf = abs_n;
      end
      if (frame_done) begin
        if (last_fd >= 0) check("frame_period", 32'(abs_n - last_fd), 32'(HT * VT * D));
        last_fd = abs_n;
      end
      prev_hs = hsync;
      prev_vs = vsync;

      if (swp) pend = 0;
      else if (frame_ready) pend = 1;
      hs_now = !((h >= HA + HFP) && (h < HA + HFP + HS));
      vs_now = !((v >= VA + VFP) && (v < VA + VFP + VS));
      hs2 = hs1; hs1 = hs_now;
      vs2 = vs1; vs1 = vs_now;
      act2 = act1; act1 = act;
      dprev = dcur;
      if (en) dcur = mem[addr];
      n++;
      abs_n++;

      if (post && n >= (VA + 2) * HT * D) done = 1;
      if (abs_n > 95000) begin
        check("run_bound", 32'd0, 32'd1);
        done = 1;
      end

      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      if (rst_now) begin
        rst = 1'b0;
        rst_now = 0;
        post = 1;
        just_reset = 1;
        model_reset();
        hrun = 0; vrun = 0;
        last_hf = -1; last_fd = -1;
        prev_hs = 1; prev_vs = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
